// File: rtl/alu_issue_stage_if.sv
// Handshake bundle between the decode/regfile stage, the ALU issue stage and the EX stage.
// A transfer happens on a rising edge where valid && ready; the sender holds payload stable while valid && !ready.
interface alu_issue_stage_if #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 4
);
  logic             id_valid;
  logic             id_ready;
  logic [XLEN-1:0]  id_rd1;
  logic [XLEN-1:0]  id_rd2;
  logic [XLEN-1:0]  id_imm;
  logic             id_alusrc;
  logic [1:0]       id_alu_op;
  logic [2:0]       id_funct3;
  logic             id_funct7_5;
  logic             ex_valid;
  logic             ex_ready;
  logic [XLEN-1:0]  rd1;
  logic [XLEN-1:0]  rd2;
  logic [SEL_W-1:0] sel;
  logic             ex_illegal;

  modport slave (
    input  id_valid, id_rd1, id_rd2, id_imm, id_alusrc, id_alu_op, id_funct3, id_funct7_5,
    input  ex_ready,
    output id_ready, ex_valid, rd1, rd2, sel, ex_illegal
  );

  modport master (
    output id_valid, id_rd1, id_rd2, id_imm, id_alusrc, id_alu_op, id_funct3, id_funct7_5,
    output ex_ready,
    input  id_ready, ex_valid, rd1, rd2, sel, ex_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes ALUOp/funct3/funct7 into the ALU select code behind a 2-entry skid buffer.
// Optional macro ALU_ISSUE_SLT_EN enables the SLT decode for funct3=010.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int SEL_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  alu_issue_stage_if.slave    bus,
  output logic [1:0]          dbg_state_o
);
  localparam logic [SEL_W-1:0] SEL_AND = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_OR  = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_ADD = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_SUB = 4'b0110;
`ifdef ALU_ISSUE_SLT_EN
  localparam logic [SEL_W-1:0] SEL_SLT = 4'b0111;
`endif

  typedef struct packed {
    logic [XLEN-1:0]  rd1;
    logic [XLEN-1:0]  rd2;
    logic [SEL_W-1:0] sel;
    logic             ill;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL1 = 2'd1,
    S_FULL2 = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, skid_q;
  entry_t dec_entry;
  logic   accept, consume;
  logic   main_ld_new, main_ld_skid, skid_ld;

  always_comb begin
    dec_entry.rd1 = bus.id_rd1;
    dec_entry.rd2 = bus.id_alusrc ? bus.id_imm : bus.id_rd2;
    dec_entry.sel = SEL_ADD;
    dec_entry.ill = 1'b0;
    case (bus.id_alu_op)
      2'b00: dec_entry.sel = SEL_ADD;
      2'b01: dec_entry.sel = SEL_SUB;
      default: begin
        case (bus.id_funct3)
          // funct7 bit 30 only selects SUB for R-type; for I-type it is immediate data.
          3'b000: dec_entry.sel = (bus.id_alu_op == 2'b10 && bus.id_funct7_5) ? SEL_SUB : SEL_ADD;
          3'b111: dec_entry.sel = SEL_AND;
          3'b110: dec_entry.sel = SEL_OR;
`ifdef ALU_ISSUE_SLT_EN
          3'b010: dec_entry.sel = SEL_SLT;
`endif
          default: begin
            dec_entry.sel = SEL_ADD;
            dec_entry.ill = 1'b1;
          end
        endcase
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    main_ld_new  = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    accept       = bus.id_valid && (state_q != S_FULL2);
    consume      = (state_q != S_EMPTY) && bus.ex_ready;
    case (state_q)
      S_EMPTY: begin
        if (accept) begin
          main_ld_new = 1'b1;
          state_d     = S_FULL1;
        end
      end
      S_FULL1: begin
        if (accept && consume) begin
          main_ld_new = 1'b1;
        end else if (accept) begin
          skid_ld = 1'b1;
          state_d = S_FULL2;
        end else if (consume) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL2: begin
        if (consume) begin
          main_ld_skid = 1'b1;
          state_d      = S_FULL1;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    // A mispredict kills everything, including a same-cycle accept.
    if (flush) begin
      state_d      = S_EMPTY;
      main_ld_new  = 1'b0;
      main_ld_skid = 1'b0;
      skid_ld      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (main_ld_new) begin
        main_q <= dec_entry;
      end else if (main_ld_skid) begin
        main_q <= skid_q;
      end
      if (skid_ld) begin
        skid_q <= dec_entry;
      end
    end
  end

  assign bus.ex_valid   = (state_q != S_EMPTY);
  assign bus.id_ready   = (state_q != S_FULL2);
  assign bus.rd1        = main_q.rd1;
  assign bus.rd2        = main_q.rd2;
  assign bus.sel        = main_q.sel;
  assign bus.ex_illegal = main_q.ill;
  assign dbg_state_o    = state_q;
endmodule
